alu_dsp_arbiter: RTL and testbench
==================================

# alu_dsp_arbiter

Shared-DSP responder: accepts the 44-bit `dsp_ins_flat` command bundles from up to `NUM_CLIENTS` ALU clients (IIR filter and similar), grants one client at a time with round-robin arbitration, and executes the granted stream on a behavioural DSP48A1-style multiply/accumulate pipeline. It returns the 84-bit `{m, p}` result bundle to all clients. It sits between the ALU clients and the single DSP slice in the synth datapath.

## Interface
- `NUM_CLIENTS`, default 4: number of client ports, range 1..8.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NUM_CLIENTS  per-client request. The client holds it high for its whole operation.
- `dsp_ins_all`  in  NUM_CLIENTS*44  client bundles; client k occupies `[44*k +: 44]`. Bundle fields, MSB first: postadd_sub, preadd_sub, cryin, use_preadd, z[1:0], x[1:0], a[17:0], b[17:0].
- `gnt`  out  NUM_CLIENTS  registered one-hot grant; all zero means no owner.
- `dsp_outs_flat`  out  84  `{m[35:0], p[47:0]}`, broadcast to every client.

## Operation
- Arbiter:
  - Grant is held while the owner's `req` stays high.
  - When the owner drops `req`, or there is no owner, the next requester in round-robin order is granted. The search starts at owner+1 (or last owner+1).
  - `gnt` is updated on the clock edge following evaluation, so at most one grant is active.
- Input mux: only the owner's bundle reaches the pipeline. With no owner, the pipeline receives an all-zero bundle, which is a zero opmode.
- Pipeline stages, all registers:
  - S1: a, b and the opmode fields are registered.
  - S2: `b' = use_preadd ? (preadd_sub ? -b : b) : b`, with D tied to 0. `m = a*b'` is a signed 18x18 product, 36 bits, registered. The opmode is delayed alongside.
  - S3: `p <= postadd_sub ? Z - (X + cryin) : Z + X + cryin`, computed in 48 bits.
- X mux: 0 zero, 1 sign-extended m, 2 p, 3 concatenation {a,b} zero-extended.
- Z mux: 0 zero, 1 zero (no PCIN), 2 p, 3 zero (C tied 0).
- Arithmetic is two's complement and wraps at 48 bits with no saturation.
- Zero-opmode bundles force p to 0 when they reach S3, so an idle pipeline self-clears.

## Timing
- Reset values: `gnt`=0, `p`=0, `m`=0, and every pipeline register is 0.
- Grant latency: if `req[k]` rises in cycle r with no owner, `gnt[k]`=1 in cycle r+1.
- The client issues its first bundle in the first cycle it sees `gnt` high. Bundles presented before that are ignored.
- Data latency:
  - A bundle presented in cycle c affects `m` visible in c+2 and `p` visible in c+3.
  - A five-term MAC issued in cycles c0..c0+4 gives its final `p` in c0+7, matching the IIR client's CALC(5)/WAIT(2)/DONE sequence.
- Handover: the owner drops `req` after its DONE cycle. The trailing zero opmodes clear `p` before any new owner's first Z=P term reaches S3, because the new owner's first bundle arrives at S3 at the earliest 3 cycles after its grant.
- If an owner drops `req` mid-operation, the grant moves on. Ops already in flight complete, and `p` carries their result for ≤3 cycles.
- Simultaneous requests: the lowest index at or after the round-robin pointer wins.
- `reset` asserted mid-operation clears all state immediately and asynchronously. After release, arbitration restarts with client 0 highest priority.

## Structure
- `globals.vh` holds:
  - opmode codes `DSP_X_IN_ZERO/MULT/POUT/DAB` (0..3) and `DSP_Z_IN_ZERO/PCIN/POUT/C` (0..3);
  - bundle field offsets;
  - widths 44 and 84.
- Sub-module `alu_dsp48_core`: the three-stage pipeline and muxes, taking one 44-bit bundle and producing 84 bits. Arbiter and input mux live in the top.

## Test plan
- Reset: assert `reset` mid-MAC. Required: `gnt`=0 and `dsp_outs_flat`=0 immediately; after release, no grant until `req` is seen.
- Single MAC: client 0 gets a grant, then issues 5 cycles of a=0x10000, b=0x08000, x=MULT, z=POUT, followed by zero bundles. Required: `p`=0x2_8000_0000 three cycles after the last bundle, `p[33:16]`=0x28000, then `p`=0 three cycles later.
- Subtract/preadd: a=3, b=5, use_preadd=1, preadd_sub=1, x=MULT, z=ZERO, one cycle. Required: `m`=-15 at c+2 and `p`=0xFFFF_FFFF_FFF1 at c+3.
- Round-robin: `req`=4'b1011 held from reset, each owner dropping `req` after 8 cycles. Required grant order is 0, 1, 3, 0.
- Handover isolation: client 0 ends a MAC with `p`≠0 and client 1 is granted the next cycle and starts a MAC with z=POUT. Required: client 1's result excludes client 0's residue.
- Wrap: accumulate 0x1FFFF×0x1FFFF repeatedly past 2^47. Required: `p` wraps modulo 2^48 with no saturation.

Source files
------------

// File: rtl/alu_dsp_arbiter_pkg.sv
// Shared definitions for the ALU-to-DSP arbiter: bundle layout, opmode codes
// and widths used by the arbiter top and the DSP48A1-style core.
package alu_dsp_arbiter_pkg;

  localparam int DSP_INS_W  = 44;
  localparam int DSP_OUTS_W = 84;

  // X-mux select codes
  localparam logic [1:0] DSP_X_IN_ZERO = 2'd0;
  localparam logic [1:0] DSP_X_IN_MULT = 2'd1;
  localparam logic [1:0] DSP_X_IN_POUT = 2'd2;
  localparam logic [1:0] DSP_X_IN_DAB  = 2'd3;

  // Z-mux select codes
  localparam logic [1:0] DSP_Z_IN_ZERO = 2'd0;
  localparam logic [1:0] DSP_Z_IN_PCIN = 2'd1;
  localparam logic [1:0] DSP_Z_IN_POUT = 2'd2;
  localparam logic [1:0] DSP_Z_IN_C    = 2'd3;

  // Bit offsets of the bundle fields (LSB of each field)
  localparam int DSP_B_LSB       = 0;
  localparam int DSP_A_LSB       = 18;
  localparam int DSP_X_LSB       = 36;
  localparam int DSP_Z_LSB       = 38;
  localparam int DSP_USE_PREADD  = 40;
  localparam int DSP_CRYIN       = 41;
  localparam int DSP_PREADD_SUB  = 42;
  localparam int DSP_POSTADD_SUB = 43;

  // Command bundle, MSB first; packs to exactly DSP_INS_W bits.
  typedef struct packed {
    logic        postadd_sub;
    logic        preadd_sub;
    logic        cryin;
    logic        use_preadd;
    logic [1:0]  z;
    logic [1:0]  x;
    logic [17:0] a;
    logic [17:0] b;
  } dsp_ins_t;

  // Sign-extend the 36-bit product onto the 48-bit post-adder.
  function automatic logic [47:0] sext_m(input logic [35:0] v);
    return {{12{v[35]}}, v};
  endfunction

endpackage

// File: rtl/alu_dsp48_core.sv
// Behavioural DSP48A1-style three-stage pipeline: register the bundle, form
// the pre-added signed product, then the X/Z post-adder with wrap-around.
module alu_dsp48_core
  import alu_dsp_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DSP_INS_W-1:0]  dsp_ins,
  output logic [DSP_OUTS_W-1:0] dsp_outs
);

  dsp_ins_t    s1_q, s1_d;
  logic [35:0] m_q, m_d;
  logic [35:0] s2_ab_q, s2_ab_d;
  logic [1:0]  s2_x_q, s2_x_d;
  logic [1:0]  s2_z_q, s2_z_d;
  logic        s2_cin_q, s2_cin_d;
  logic        s2_sub_q, s2_sub_d;
  logic [47:0] p_q, p_d;

  logic [17:0] b_pre;
  logic [35:0] a_se, b_se;
  logic [47:0] x_val, z_val;

  // Next-state for all three stages: pre-adder/multiplier and post-adder muxes
  always_comb begin
    s1_d = dsp_ins_t'(dsp_ins);

    // D is tied to zero, so the pre-adder only negates or passes B
    b_pre = (s1_q.use_preadd && s1_q.preadd_sub) ? (18'd0 - s1_q.b) : s1_q.b;
    a_se  = {{18{s1_q.a[17]}}, s1_q.a};
    b_se  = {{18{b_pre[17]}}, b_pre};
    // Low 36 bits of the sign-extended product equal the signed 18x18 product
    m_d      = a_se * b_se;
    s2_ab_d  = {s1_q.a, s1_q.b};
    s2_x_d   = s1_q.x;
    s2_z_d   = s1_q.z;
    s2_cin_d = s1_q.cryin;
    s2_sub_d = s1_q.postadd_sub;

    x_val = '0;
    case (s2_x_q)
      DSP_X_IN_ZERO: x_val = '0;
      DSP_X_IN_MULT: x_val = sext_m(m_q);
      DSP_X_IN_POUT: x_val = p_q;
      DSP_X_IN_DAB:  x_val = {12'd0, s2_ab_q};
      default:       x_val = '0;
    endcase
    // No cascade input and C tied to zero: only P feeds the Z side
    z_val = (s2_z_q == DSP_Z_IN_POUT) ? p_q : '0;

    // An all-zero opmode clears P so an idle pipeline drains to zero
    if (s2_x_q == DSP_X_IN_ZERO && s2_z_q == DSP_Z_IN_ZERO) begin
      p_d = '0;
    end else if (s2_sub_q) begin
      p_d = z_val - (x_val + {47'd0, s2_cin_q});
    end else begin
      p_d = z_val + x_val + {47'd0, s2_cin_q};
    end
  end

  // Pipeline registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      m_q      <= '0;
      s2_ab_q  <= '0;
      s2_x_q   <= '0;
      s2_z_q   <= '0;
      s2_cin_q <= 1'b0;
      s2_sub_q <= 1'b0;
      p_q      <= '0;
    end else begin
      s1_q     <= s1_d;
      m_q      <= m_d;
      s2_ab_q  <= s2_ab_d;
      s2_x_q   <= s2_x_d;
      s2_z_q   <= s2_z_d;
      s2_cin_q <= s2_cin_d;
      s2_sub_q <= s2_sub_d;
      p_q      <= p_d;
    end
  end

  assign dsp_outs = {m_q, p_q};

endmodule

// File: rtl/alu_dsp_arbiter.sv
// Round-robin arbiter that lends the single DSP slice to one ALU client at a
// time; only the owner's bundle enters the pipeline, results go to everyone.
module alu_dsp_arbiter
  import alu_dsp_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS*DSP_INS_W-1:0] dsp_ins_all,
  output logic [NUM_CLIENTS-1:0]           gnt,
  output logic [DSP_OUTS_W-1:0]            dsp_outs_flat
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  // Index of the most recent owner; the round-robin search starts after it
  logic [IW-1:0]          last_q, last_d;

  logic                   hold;
  logic                   found;
  logic [IW-1:0]          cand;

  logic [DSP_INS_W-1:0]   masked [NUM_CLIENTS];
  logic [DSP_INS_W-1:0]   sel_bundle;

  // Keep the owner while it requests; otherwise pick the next requester
  always_comb begin
    gnt_d  = gnt_q;
    last_d = last_q;
    found  = 1'b0;
    cand   = '0;
    hold   = |(gnt_q & req);
    if (!hold) begin
      gnt_d = '0;
      // i runs 1..N so the previous owner is considered last
      for (int i = 1; i <= NUM_CLIENTS; i++) begin
        cand = IW'((int'(last_q) + i) % NUM_CLIENTS);
        if (!found && req[cand]) begin
          found       = 1'b1;
          gnt_d[cand] = 1'b1;
          last_d      = cand;
        end
      end
    end
  end

  // Grant state; after reset the pointer sits on the last client so client 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= '0;
      last_q <= IW'(NUM_CLIENTS - 1);
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  // Each client's bundle is gated by its one-hot grant bit
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_mask
    assign masked[gi] = dsp_ins_all[DSP_INS_W*gi +: DSP_INS_W] & {DSP_INS_W{gnt_q[gi]}};
  end

  // OR the gated bundles; with no owner this yields the all-zero opmode
  always_comb begin
    sel_bundle = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      sel_bundle = sel_bundle | masked[i];
    end
  end

  alu_dsp48_core u_core (
    .clk      (clk),
    .reset    (reset),
    .dsp_ins  (sel_bundle),
    .dsp_outs (dsp_outs_flat)
  );

  assign gnt = gnt_q;

endmodule

// File: tb/tb_alu_dsp_arbiter.sv
// Bench for alu_dsp_arbiter: a cycle-level reference model (owner index plus a
// history queue of presented bundles) checked every cycle, plus hand-computed
// expectations for the MAC, pre-add, round-robin, handover, reset and wrap cases.
module tb_alu_dsp_arbiter;
  import alu_dsp_arbiter_pkg::*;

  localparam int NC = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        req;
  logic [NC*44-1:0]     ins;
  logic [NC-1:0]        gnt;
  logic [83:0]          outs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_dsp_arbiter #(.NUM_CLIENTS(NC)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .dsp_ins_all   (ins),
    .gnt           (gnt),
    .dsp_outs_flat (outs)
  );

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint prod_of(input logic [43:0] bnd);
    dsp_ins_t s;
    int sa, sb;
    s  = bnd;
    sa = $signed(s.a);
    sb = $signed(s.b);
    if (s.use_preadd && s.preadd_sub) sb = -sb;
    if (sb == 131072) sb = -131072;   // negating the most negative B wraps in 18 bits
    return longint'(sa) * longint'(sb);
  endfunction

  function automatic logic [47:0] p_of(input logic [43:0] bnd, input logic [47:0] pold);
    dsp_ins_t s;
    longint pr;
    logic [47:0] xv, zv;
    s  = bnd;
    pr = prod_of(bnd);
    case (s.x)
      2'd0: xv = '0;
      2'd1: xv = pr[47:0];
      2'd2: xv = pold;
      default: xv = {12'd0, s.a, s.b};
    endcase
    zv = (s.z == 2'd2) ? pold : 48'd0;
    if (s.x == 2'd0 && s.z == 2'd0) return 48'd0;
    if (s.postadd_sub) return zv - xv - 48'(s.cryin);
    return zv + xv + 48'(s.cryin);
  endfunction

  int          owner_m = -1;
  int          last_m  = NC - 1;
  logic [35:0] m_m     = '0;
  logic [47:0] p_m     = '0;
  logic [43:0] hist[$] = '{44'd0, 44'd0, 44'd0};

  // hist[0] is the bundle taken at this edge, hist[1] one edge earlier, hist[2] two
  always @(posedge clk or posedge reset) begin
    logic [43:0] pres;
    longint      pr;
    int          nxt, c;
    if (reset) begin
      owner_m = -1;
      last_m  = NC - 1;
      m_m     = '0;
      p_m     = '0;
      hist    = '{44'd0, 44'd0, 44'd0};
    end else begin
      pres = '0;
      if (owner_m >= 0) pres = ins[44*owner_m +: 44];
      hist.push_front(pres);
      p_m = p_of(hist[2], p_m);
      pr  = prod_of(hist[1]);
      m_m = pr[35:0];
      void'(hist.pop_back());
      if (!(owner_m >= 0 && req[owner_m])) begin
        nxt = -1;
        for (int i = 1; i <= NC; i++) begin
          c = (last_m + i) % NC;
          if (nxt < 0 && req[c]) nxt = c;
        end
        owner_m = nxt;
        if (nxt >= 0) last_m = nxt;
      end
    end
  end

  // Every-cycle comparison of grant and result bundle against the model
  always @(negedge clk) begin
    logic [NC-1:0] g;
    g = '0;
    if (owner_m >= 0) g[owner_m] = 1'b1;
    chk("cycle_gnt", {80'd0, gnt}, {80'd0, g});
    chk("cycle_out", outs, {m_m, p_m});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] mk(input bit psub, input bit presub, input bit cin,
                                     input bit upre, input logic [1:0] z, input logic [1:0] x,
                                     input logic [17:0] a, input logic [17:0] b);
    logic [43:0] v;
    v = '0;
    v[DSP_POSTADD_SUB]          = psub;
    v[DSP_PREADD_SUB]           = presub;
    v[DSP_CRYIN]                = cin;
    v[DSP_USE_PREADD]           = upre;
    v[DSP_Z_LSB +: 2]           = z;
    v[DSP_X_LSB +: 2]           = x;
    v[DSP_A_LSB +: 18]          = a;
    v[DSP_B_LSB +: 18]          = b;
    return v;
  endfunction

  task automatic wait_gnt(input int k);
    for (int n = 0; n < 20 && !gnt[k]; n++) tick();
    checks++;
    if (!gnt[k]) begin
      failures++;
      $display("FAIL grant_wait client=%0d actual=%b required=grant", k, gnt);
    end
  endtask

  int          order[4];
  logic [63:0] rnd;
  logic [43:0] mac_w;

  initial begin
    reset = 1'b1;
    req   = '0;
    ins   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_gnt", {80'd0, gnt}, 84'd0);
    chk("reset_out", outs, 84'd0);

    // Single MAC on client 0
    req[0] = 1'b1;
    tick();
    chk("grant_latency", {80'd0, gnt}, 84'h1);
    for (int i = 0; i < 5; i++) begin
      ins[0 +: 44] = mk(0, 0, 0, 0, DSP_Z_IN_POUT, DSP_X_IN_MULT, 18'h10000, 18'h08000);
      tick();
    end
    ins[0 +: 44] = '0;
    tick();
    tick();
    chk("mac_p", {36'd0, outs[47:0]}, 84'h2_8000_0000);
    chk("mac_p_slice", {66'd0, outs[33:16]}, 84'h28000);
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    chk("mac_clear", {36'd0, outs[47:0]}, 84'd0);

    // Pre-adder subtract on client 2
    req[2] = 1'b1;
    wait_gnt(2);
    ins[88 +: 44] = mk(0, 1, 0, 1, DSP_Z_IN_ZERO, DSP_X_IN_MULT, 18'd3, 18'd5);
    tick();
    ins[88 +: 44] = '0;
    tick();
    chk("preadd_m", {48'd0, outs[83:48]}, {48'd0, 36'hF_FFFF_FFF1});
    tick();
    chk("preadd_p", {36'd0, outs[47:0]}, {36'd0, 48'hFFFF_FFFF_FFF1});
    req[2] = 1'b0;
    repeat (4) tick();

    // Handover: client 0 finishes with a residue, client 1 takes over
    req[0] = 1'b1;
    req[1] = 1'b1;
    wait_gnt(0);
    for (int i = 0; i < 5; i++) begin
      ins[0 +: 44] = mk(0, 0, 0, 0, DSP_Z_IN_POUT, DSP_X_IN_MULT, 18'h100, 18'h100);
      tick();
    end
    ins[0 +: 44] = '0;
    tick();
    tick();
    chk("handover_p0", {36'd0, outs[47:0]}, 84'h50000);
    tick();
    req[0] = 1'b0;
    wait_gnt(1);
    for (int i = 0; i < 3; i++) begin
      ins[44 +: 44] = mk(0, 0, 0, 0, DSP_Z_IN_POUT, DSP_X_IN_MULT, 18'd2, 18'd3);
      tick();
    end
    ins[44 +: 44] = '0;
    tick();
    tick();
    chk("handover_p1", {36'd0, outs[47:0]}, 84'd18);
    req[1] = 1'b0;
    repeat (5) tick();

    // Round-robin with req=1011 held from reset
    reset = 1'b1;
    req   = 4'b1011;
    for (int k = 0; k < NC; k++) begin
      rnd = {$urandom(), $urandom()};
      ins[44*k +: 44] = rnd[43:0];
    end
    tick();
    tick();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int n = 0; n < 20 && gnt == '0; n++) tick();
      order[j] = -1;
      for (int i = 0; i < NC; i++) if (gnt[i]) order[j] = i;
      if (order[j] < 0) begin
        checks++;
        failures++;
        $display("FAIL rr_wait actual=%b required=grant", gnt);
      end else begin
        repeat (7) tick();
        req[order[j]] = 1'b0;
        tick();
        req[order[j]] = 1'b1;
      end
    end
    chk("rr_order0", 84'(order[0]), 84'd0);
    chk("rr_order1", 84'(order[1]), 84'd1);
    chk("rr_order2", 84'(order[2]), 84'd3);
    chk("rr_order3", 84'(order[3]), 84'd0);
    req = '0;
    ins = '0;
    repeat (5) tick();

    // Reset asserted in the middle of a MAC
    req[0] = 1'b1;
    wait_gnt(0);
    for (int i = 0; i < 3; i++) begin
      ins[0 +: 44] = mk(0, 0, 0, 0, DSP_Z_IN_POUT, DSP_X_IN_MULT, 18'h1234, 18'h0567);
      tick();
    end
    #2;
    reset = 1'b1;
    req   = '0;
    ins   = '0;
    #1;
    chk("reset_async_gnt", {80'd0, gnt}, 84'd0);
    chk("reset_async_out", outs, 84'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_after_reset", {80'd0, gnt}, 84'd0);
    end
    req = 4'b1100;
    tick();
    chk("post_reset_prio", {80'd0, gnt}, 84'h4);
    req = '0;
    repeat (4) tick();

    // Wrap: 16400 x (0x1FFFF^2) overflows 2^48 once
    req[0] = 1'b1;
    wait_gnt(0);
    mac_w = mk(0, 0, 0, 0, DSP_Z_IN_POUT, DSP_X_IN_MULT, 18'h1FFFF, 18'h1FFFF);
    for (int i = 0; i < 16400; i++) begin
      ins[0 +: 44] = mac_w;
      tick();
    end
    ins[0 +: 44] = '0;
    tick();
    tick();
    chk("wrap_p", {36'd0, outs[47:0]}, {36'd0, 48'h003E_FFC0_4010});
    req[0] = 1'b0;
    repeat (4) tick();

    // Random requests and bundles against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
        rnd = {$urandom(), $urandom()};
        ins[44*k +: 44] = rnd[43:0];
      end
      tick();
    end
    req = '0;
    ins = '0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
